pc_fetch: RTL and testbench
===========================

PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 Parameter WIDTH, default 32, address/data-path width in bits.
REQ-002 Parameter RESET_PC, default 0, fetch address loaded on reset.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset, with ports as follows:
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hold fetch and decode outputs.
- PCsrc  in  1  branch taken for the instruction currently on Instr.
- ImmOp  in  WIDTH  sign/zero-extended immediate returned by the extend stage.
- imem_addr  out  WIDTH  instruction memory read address.
- imem_en  out  1  instruction memory read enable.
- imem_rdata  in  32  instruction word; synchronous read, valid one cycle after imem_addr/imem_en.
- Instr  out  32  instruction presented to decode.
- PC_ID  out  WIDTH  address of Instr.
- InstrValid  out  1  Instr/PC_ID hold a real instruction.
- Imm  out  12  immediate field extracted from Instr, fed to extend.

Function
REQ-004 The block SHALL hold registers: fetch PC (pc), in-flight PC (if_pc), in-flight valid (if_v).
REQ-005 The block SHALL drive imem_addr = pc and imem_en = !stall | redirect, where redirect = PCsrc & InstrValid.
REQ-006 The block SHALL drive Instr = imem_rdata, PC_ID = if_pc, and InstrValid = if_v, with no added latency.
REQ-007 Sequential fetch (no rst, no redirect, !stall): pc <= pc+4, if_pc <= pc, if_v <= 1.
REQ-008 Stall (no redirect): pc, if_pc, and if_v SHALL hold; memory is disabled, so Instr holds.
REQ-009 Redirect SHALL take priority over stall: pc <= PC_ID + (ImmOp << 1), if_v <= 0 (squash the sequential fetch), if_pc <= pc.
REQ-010 After a redirect, the target instruction SHALL appear on Instr with InstrValid=1 exactly two cycles after the redirect edge, with one bubble cycle between.
REQ-011 PCsrc SHALL be ignored while InstrValid=0.
REQ-012 All PC arithmetic SHALL be modulo 2^WIDTH: pc+4 wraps to 0, and target addition wraps.
REQ-013 Imm extraction:
- If Instr[6:0] = 7'b1100011 (branch): Imm = {Instr[31], Instr[7], Instr[30:25], Instr[11:8]}, an offset in halfwords.
- Otherwise: Imm = Instr[31:20].
- Imm is combinational from Instr.
REQ-014 The block SHALL NOT check alignment; the low two bits of the target pass through unchanged.

Reset
REQ-015 On rst=1 at a rising edge: pc <= RESET_PC, if_pc <= RESET_PC, if_v <= 0; rst overrides redirect and stall.
REQ-016 In the first cycle after reset release: imem_addr=RESET_PC, imem_en=1 (when !stall), InstrValid=0.
REQ-017 The instruction at RESET_PC SHALL appear with InstrValid=1 one cycle after reset release.

Verification
REQ-018 Reset release, RESET_PC=0, stall=0 -> imem_addr 0,4,8,...; InstrValid 0 then 1; PC_ID 0,4,... one cycle behind imem_addr.
REQ-019 PC_ID=0x8, InstrValid=1, PCsrc=1, ImmOp=0x8 -> next cycle imem_addr=0x18, InstrValid=0; following cycle PC_ID=0x18, InstrValid=1.
REQ-020 Instr=0xFE000EE3 (beq, -4) at PC_ID=0x10 -> Imm=0xFFE; with ImmOp=0xFFFFFFFE and PCsrc=1, next imem_addr=0xC. Instr=0xFFF00093 -> Imm=0xFFF.
REQ-021 stall=1 for 3 cycles mid-stream -> imem_addr, imem_en=0, Instr, PC_ID, and InstrValid all held; on release, the sequence resumes with no skipped or duplicated PC.
REQ-022 stall=1 and redirect in the same cycle -> redirect taken per REQ-009.
REQ-023 RESET_PC=0xFFFFFFFC -> imem_addr 0xFFFFFFFC then 0x0.
REQ-024 rst=1 together with PCsrc=1 and valid -> imem_addr=RESET_PC next cycle and InstrValid=0.

Source files
------------

// File: rtl/pc_fetch.sv
// ----------------------------------------------------------------------------
// pc_fetch -- instruction fetch stage with a one-deep in-flight slot.
//
// The fetch PC (pc_q) addresses a synchronous-read instruction memory. The
// word returned one cycle later is presented directly to decode as Instr,
// tagged with the address it came from (PC_ID) and a valid bit (InstrValid).
// A taken branch on the decoded instruction redirects fetch to
// PC_ID + (ImmOp << 1) and squashes the sequential fetch already issued.
//
// Ports
//   clk         in   sole clock, rising edge
//   rst         in   synchronous, active-high reset
//   stall       in   hold fetch and decode outputs
//   PCsrc       in   branch taken for the instruction on Instr
//   ImmOp       in   extended immediate (halfword offset) from extend stage
//   imem_addr   out  instruction memory read address
//   imem_en     out  instruction memory read enable
//   imem_rdata  in   instruction word, valid one cycle after addr/en
//   Instr       out  instruction presented to decode
//   PC_ID       out  address of Instr
//   InstrValid  out  Instr/PC_ID hold a real instruction
//   Imm         out  12-bit immediate field extracted from Instr
// ----------------------------------------------------------------------------
module pc_fetch #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             PCsrc,
    input  logic [WIDTH-1:0] ImmOp,
    output logic [WIDTH-1:0] imem_addr,
    output logic             imem_en,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      Instr,
    output logic [WIDTH-1:0] PC_ID,
    output logic             InstrValid,
    output logic [11:0]      Imm
);

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_d;
    logic [WIDTH-1:0] if_pc_q;
    logic [WIDTH-1:0] if_pc_d;
    logic             if_v_q;
    logic             if_v_d;
    logic             redirect;

    // A branch can only be taken by a real instruction; PCsrc against a
    // bubble is meaningless and ignored.
    assign redirect = PCsrc & if_v_q;

    assign imem_addr  = pc_q;
    // Memory stays enabled on a redirect even under stall so the slot is
    // refilled (and then squashed) consistently with if_pc.
    assign imem_en    = ~stall | redirect;
    assign Instr      = imem_rdata;
    assign PC_ID      = if_pc_q;
    assign InstrValid = if_v_q;

    always_comb begin
        pc_d    = pc_q;
        if_pc_d = if_pc_q;
        if_v_d  = if_v_q;
        if (redirect) begin
            // Target is relative to the branch itself; the word fetched this
            // cycle (at pc_q) is the wrong path and is marked invalid.
            pc_d    = if_pc_q + (ImmOp << 1);
            if_pc_d = pc_q;
            if_v_d  = 1'b0;
        end else if (!stall) begin
            pc_d    = pc_q + WIDTH'(4);
            if_pc_d = pc_q;
            if_v_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            if_pc_q <= RESET_PC;
            if_v_q  <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            if_pc_q <= if_pc_d;
            if_v_q  <= if_v_d;
        end
    end

    // Branches carry a scattered B-type offset in halfwords; everything else
    // uses the I-type field in the top 12 bits.
    always_comb begin
        Imm = Instr[31:20];
        if (Instr[6:0] == OPC_BRANCH) begin
            Imm = {Instr[31], Instr[7], Instr[30:25], Instr[11:8]};
        end
    end

endmodule

// File: tb/tb_pc_fetch.sv
module tb_pc_fetch;

    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        stall;
    logic        PCsrc;
    logic [31:0] ImmOp;

    logic [31:0] imem_addr,   imem_rdata,   Instr,   PC_ID;
    logic        imem_en,     InstrValid;
    logic [11:0] Imm;
    logic [31:0] imem_addr_b, imem_rdata_b, Instr_b, PC_ID_b;
    logic        imem_en_b,   InstrValid_b;
    logic [11:0] Imm_b;

    pc_fetch dut (
        .clk(clk), .rst(rst), .stall(stall), .PCsrc(PCsrc), .ImmOp(ImmOp),
        .imem_addr(imem_addr), .imem_en(imem_en), .imem_rdata(imem_rdata),
        .Instr(Instr), .PC_ID(PC_ID), .InstrValid(InstrValid), .Imm(Imm)
    );

    pc_fetch #(.WIDTH(32), .RESET_PC(WRAP_PC)) dut_b (
        .clk(clk), .rst(rst), .stall(stall), .PCsrc(PCsrc), .ImmOp(ImmOp),
        .imem_addr(imem_addr_b), .imem_en(imem_en_b), .imem_rdata(imem_rdata_b),
        .Instr(Instr_b), .PC_ID(PC_ID_b), .InstrValid(InstrValid_b), .Imm(Imm_b)
    );

    // Synchronous-read instruction memory shared by both instances.
    logic [31:0] mem [0:255];
    always @(posedge clk) begin
        if (imem_en)   imem_rdata   <= mem[imem_addr[9:2]];
        if (imem_en_b) imem_rdata_b <= mem[imem_addr_b[9:2]];
    end

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: next address to fetch, the decode slot, and the
    // word currently held at the memory output.
    logic [31:0] m_pc      = '0;
    logic [31:0] m_slot_pc = '0;
    logic        m_slot_v  = 1'b0;
    logic [31:0] m_instr   = '0;

    // Immediate as decode sees it: branches give the B-type byte offset
    // expressed in halfwords, others the I-type field.
    function automatic logic [11:0] ref_imm(input logic [31:0] ins);
        logic [31:0] byte_off;
        if (ins[6:0] == 7'h63) begin
            byte_off = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            return byte_off[12:1];
        end
        return ins[31:20];
    endfunction

    logic [109:0] obs;
    assign obs = {imem_addr, imem_en, PC_ID, InstrValid, Instr, Imm};

    function automatic logic [109:0] expect_now();
        logic en;
        en = !stall || (PCsrc && m_slot_v);
        return {m_pc, en, m_slot_pc, m_slot_v, m_instr, ref_imm(m_instr)};
    endfunction

    task automatic apply(input logic r, input logic s, input logic p, input logic [31:0] imm);
        rst   = r;
        stall = s;
        PCsrc = p;
        ImmOp = imm;
        #1;
    endtask

    // Advance the model across one rising edge using the applied inputs,
    // then wait for the DUT to take the same edge.
    task automatic tick();
        logic        taken;
        logic        en;
        logic [31:0] target;
        taken  = PCsrc && m_slot_v;
        en     = !stall || taken;
        target = m_slot_pc + ImmOp * 2;
        if (en) m_instr = mem[m_pc[9:2]];
        if (rst) begin
            m_pc      = 32'h0;
            m_slot_pc = 32'h0;
            m_slot_v  = 1'b0;
        end else if (taken) begin
            m_slot_pc = m_pc;
            m_pc      = target;
            m_slot_v  = 1'b0;
        end else if (!stall) begin
            m_slot_pc = m_pc;
            m_pc      = m_pc + 32'd4;
            m_slot_v  = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        apply(1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        apply(1'b1, 1'b0, 1'b0, 32'h0);
        tick();
    endtask

    task automatic run_seq(input int n);
        for (int i = 0; i < n; i++) begin
            apply(1'b0, 1'b0, 1'b0, 32'h0);
            tick();
        end
    endtask

    task automatic test_reset();
        do_reset();
        apply(1'b0, 1'b0, 1'b0, $urandom());
        vectors++;
        if ({imem_addr, imem_en, InstrValid} !== {32'h0, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_release: got addr=%h en=%b v=%b want addr=0 en=1 v=0", imem_addr, imem_en, InstrValid);
        end
        vectors++;
        if (obs !== expect_now()) begin
            miscompares++;
            $display("FAIL reset_model: got %h want %h", obs, expect_now());
        end
        for (int k = 1; k <= 4; k++) begin
            tick();
            apply(1'b0, 1'b0, 1'b0, 32'h0);
            vectors++;
            if ({imem_addr, PC_ID, InstrValid, Instr} !== {32'(4 * k), 32'(4 * (k - 1)), 1'b1, mem[k - 1]}) begin
                miscompares++;
                $display("FAIL reset_seq%0d: got addr=%h pc_id=%h v=%b instr=%h want addr=%h pc_id=%h v=1 instr=%h",
                         k, imem_addr, PC_ID, InstrValid, Instr, 32'(4 * k), 32'(4 * (k - 1)), mem[k - 1]);
            end
        end
        tick();
    endtask

    task automatic test_redirect();
        do_reset();
        run_seq(3);
        apply(1'b0, 1'b0, 1'b1, 32'h8);
        vectors++;
        if ({PC_ID, InstrValid, imem_en} !== {32'h8, 1'b1, 1'b1}) begin
            miscompares++;
            $display("FAIL redir_pre: got pc_id=%h v=%b en=%b want 8 1 1", PC_ID, InstrValid, imem_en);
        end
        tick();
        apply(1'b0, 1'b0, 1'b0, 32'h0);
        vectors++;
        if ({imem_addr, InstrValid} !== {32'h18, 1'b0}) begin
            miscompares++;
            $display("FAIL redir_bubble: got addr=%h v=%b want 18 0", imem_addr, InstrValid);
        end
        tick();
        apply(1'b0, 1'b0, 1'b0, 32'h0);
        vectors++;
        if ({PC_ID, InstrValid, Instr} !== {32'h18, 1'b1, mem[6]}) begin
            miscompares++;
            $display("FAIL redir_target: got pc_id=%h v=%b instr=%h want 18 1 %h", PC_ID, InstrValid, Instr, mem[6]);
        end
        tick();
    endtask

    task automatic test_branch_imm();
        do_reset();
        run_seq(5);
        apply(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE);
        vectors++;
        if ({PC_ID, InstrValid, Instr, Imm} !== {32'h10, 1'b1, 32'hFE00_0EE3, 12'hFFE}) begin
            miscompares++;
            $display("FAIL beq_imm: got pc_id=%h v=%b instr=%h imm=%h want 10 1 fe000ee3 ffe", PC_ID, InstrValid, Instr, Imm);
        end
        tick();
        apply(1'b0, 1'b0, 1'b0, 32'h0);
        vectors++;
        if ({imem_addr, InstrValid} !== {32'hC, 1'b0}) begin
            miscompares++;
            $display("FAIL beq_target: got addr=%h v=%b want c 0", imem_addr, InstrValid);
        end
        tick();
        apply(1'b0, 1'b0, 1'b0, 32'h0);
        vectors++;
        if ({PC_ID, InstrValid, Instr, Imm} !== {32'hC, 1'b1, 32'hFFF0_0093, 12'hFFF}) begin
            miscompares++;
            $display("FAIL itype_imm: got pc_id=%h v=%b instr=%h imm=%h want c 1 fff00093 fff", PC_ID, InstrValid, Instr, Imm);
        end
        tick();
    endtask

    task automatic test_stall();
        do_reset();
        run_seq(3);
        for (int k = 0; k < 3; k++) begin
            apply(1'b0, 1'b1, 1'b0, $urandom());
            vectors++;
            if ({imem_addr, imem_en, PC_ID, InstrValid, Instr} !== {32'hC, 1'b0, 32'h8, 1'b1, mem[2]}) begin
                miscompares++;
                $display("FAIL stall_hold%0d: got addr=%h en=%b pc_id=%h v=%b instr=%h want c 0 8 1 %h",
                         k, imem_addr, imem_en, PC_ID, InstrValid, Instr, mem[2]);
            end
            tick();
        end
        apply(1'b0, 1'b0, 1'b0, 32'h0);
        vectors++;
        if ({imem_addr, imem_en, PC_ID, InstrValid} !== {32'hC, 1'b1, 32'h8, 1'b1}) begin
            miscompares++;
            $display("FAIL stall_release: got addr=%h en=%b pc_id=%h v=%b want c 1 8 1", imem_addr, imem_en, PC_ID, InstrValid);
        end
        tick();
        apply(1'b0, 1'b0, 1'b0, 32'h0);
        vectors++;
        if ({imem_addr, PC_ID, InstrValid, Instr} !== {32'h10, 32'hC, 1'b1, mem[3]}) begin
            miscompares++;
            $display("FAIL stall_resume: got addr=%h pc_id=%h v=%b instr=%h want 10 c 1 %h", imem_addr, PC_ID, InstrValid, Instr, mem[3]);
        end
        tick();
    endtask

    task automatic test_stall_redirect();
        do_reset();
        run_seq(3);
        apply(1'b0, 1'b1, 1'b1, 32'h20);
        vectors++;
        if (imem_en !== 1'b1) begin
            miscompares++;
            $display("FAIL stallredir_en: got en=%b want 1", imem_en);
        end
        tick();
        apply(1'b0, 1'b0, 1'b0, 32'h0);
        vectors++;
        if ({imem_addr, InstrValid} !== {32'h48, 1'b0}) begin
            miscompares++;
            $display("FAIL stallredir_addr: got addr=%h v=%b want 48 0", imem_addr, InstrValid);
        end
        tick();
        apply(1'b0, 1'b0, 1'b0, 32'h0);
        vectors++;
        if ({PC_ID, InstrValid} !== {32'h48, 1'b1}) begin
            miscompares++;
            $display("FAIL stallredir_target: got pc_id=%h v=%b want 48 1", PC_ID, InstrValid);
        end
        tick();
    endtask

    task automatic test_reset_redirect();
        do_reset();
        run_seq(3);
        apply(1'b1, 1'b0, 1'b1, 32'h20);
        tick();
        apply(1'b0, 1'b0, 1'b0, 32'h0);
        vectors++;
        if ({imem_addr, InstrValid} !== {32'h0, 1'b0}) begin
            miscompares++;
            $display("FAIL rst_over_redir: got addr=%h v=%b want 0 0", imem_addr, InstrValid);
        end
        tick();
    endtask

    task automatic test_ignore_pcsrc();
        do_reset();
        apply(1'b0, 1'b0, 1'b1, 32'h100);
        tick();
        apply(1'b0, 1'b0, 1'b0, 32'h0);
        vectors++;
        if ({imem_addr, PC_ID, InstrValid} !== {32'h4, 32'h0, 1'b1}) begin
            miscompares++;
            $display("FAIL pcsrc_invalid: got addr=%h pc_id=%h v=%b want 4 0 1", imem_addr, PC_ID, InstrValid);
        end
        tick();
    endtask

    task automatic test_wrap();
        do_reset();
        apply(1'b0, 1'b0, 1'b0, 32'h0);
        vectors++;
        if ({imem_addr_b, imem_en_b, InstrValid_b} !== {WRAP_PC, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL wrap_first: got addr=%h en=%b v=%b want fffffffc 1 0", imem_addr_b, imem_en_b, InstrValid_b);
        end
        tick();
        apply(1'b0, 1'b0, 1'b0, 32'h0);
        vectors++;
        if ({imem_addr_b, PC_ID_b, InstrValid_b, Instr_b, Imm_b} !== {32'h0, WRAP_PC, 1'b1, mem[255], ref_imm(mem[255])}) begin
            miscompares++;
            $display("FAIL wrap_second: got addr=%h pc_id=%h v=%b instr=%h imm=%h want 0 fffffffc 1 %h %h",
                     imem_addr_b, PC_ID_b, InstrValid_b, Instr_b, Imm_b, mem[255], ref_imm(mem[255]));
        end
        tick();
        apply(1'b0, 1'b0, 1'b0, 32'h0);
        vectors++;
        if ({imem_addr_b, PC_ID_b} !== {32'h4, 32'h0}) begin
            miscompares++;
            $display("FAIL wrap_third: got addr=%h pc_id=%h want 4 0", imem_addr_b, PC_ID_b);
        end
        tick();
    endtask

    task automatic test_random();
        logic        r;
        logic        s;
        logic        p;
        logic [31:0] imm;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            r   = ($urandom_range(0, 99) < 2);
            s   = ($urandom_range(0, 99) < 25);
            p   = ($urandom_range(0, 99) < 30);
            imm = ($urandom_range(0, 3) == 0) ? $urandom() : 32'($signed($urandom_range(0, 63)) - 32);
            apply(r, s, p, imm);
            vectors++;
            if (obs !== expect_now()) begin
                miscompares++;
                $display("FAIL random_%0d: got %h want %h", n, obs, expect_now());
            end
            tick();
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = $urandom();
        mem[3] = 32'hFFF0_0093;
        mem[4] = 32'hFE00_0EE3;
        test_reset();
        test_redirect();
        test_branch_imm();
        test_stall();
        test_stall_redirect();
        test_reset_redirect();
        test_ignore_pcsrc();
        test_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
